// File: rtl/full_adder_reg.sv
// Registered WIDTH-bit ripple-carry adder built from identical full-adder cells.
// {carry_out, sum} = src1 + src2 + carry_in. The result appears one clock later,
// and out_valid is the registered copy of in_valid. With WIDTH=1 this is the
// classic single-bit full adder delayed by one cycle.
module full_adder_reg #(
  parameter int WIDTH = 1  // legal range 1..64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             out_valid
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d;
  logic             carry_out_d;
  logic             out_valid_d;

  logic [WIDTH-1:0] sum_q;
  logic             carry_out_q;
  logic             out_valid_q;

  // Ripple chain: each cell adds one bit pair plus the carry from the cell below.
  always_comb begin
    // NOTE: every variable gets a default before any conditional or loop write,
    // so no path can leave it unassigned and infer a latch.
    carry       = '0;
    sum_d       = '0;
    carry[0]    = carry_in;
    for (int i = 0; i < WIDTH; i++) begin
      sum_d[i]     = src1[i] ^ src2[i] ^ carry[i];
      carry[i + 1] = (src1[i] & src2[i]) | (carry[i] & (src1[i] ^ src2[i]));
    end
    carry_out_d = carry[WIDTH];
    // Data updates every cycle; out_valid alone tells downstream whether to use it.
    out_valid_d = in_valid;
  end

  // Output registers; reset clears them at once, without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    if (rst) begin
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      carry_out_q <= carry_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sum       = sum_q;
  assign carry_out = carry_out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_full_adder_reg.sv
// Directed bench for full_adder_reg: a 1-bit instance for the truth table and
// reset behaviour, and an 8-bit instance for carry ripple, wrap and streaming.
module tb_full_adder_reg;

  logic       clk;
  logic       rst;

  logic       v1, a1, b1, c1;
  logic       s1, co1, ov1;

  logic       v8, c8;
  logic [7:0] a8, b8;
  logic [7:0] s8;
  logic       co8, ov8;

  int n_cmp;
  int n_err;

  full_adder_reg #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v1),
    .src1      (a1),
    .src2      (b1),
    .carry_in  (c1),
    .sum       (s1),
    .carry_out (co1),
    .out_valid (ov1)
  );

  full_adder_reg #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v8),
    .src1      (a8),
    .src2      (b8),
    .carry_in  (c8),
    .sum       (s8),
    .carry_out (co8),
    .out_valid (ov8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait for the next rising edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Truth-table vectors {src1, src2, carry_in} and expected {sum, carry_out}.
  logic [2:0] tt_in  [8];
  logic [1:0] tt_exp [8];

  logic [8:0] exp9;

  initial begin
    n_cmp = 0;
    n_err = 0;
    tt_in  = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b001, 3'b011, 3'b101, 3'b111};
    tt_exp = '{2'b00,  2'b10,  2'b10,  2'b01,  2'b10,  2'b01,  2'b01,  2'b11};

    rst = 1'b1;
    v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    v8 = 1'b0; a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;

    // Reset state.
    #2;
    check("rst_sum1", 64'(s1), 64'd0);
    check("rst_co1",  64'(co1), 64'd0);
    check("rst_ov1",  64'(ov1), 64'd0);
    check("rst_sum8", 64'(s8), 64'd0);
    check("rst_ov8",  64'(ov8), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // WIDTH=1 truth table, one vector per cycle.
    for (int i = 0; i < 8; i++) begin
      {a1, b1, c1} = tt_in[i];
      v1 = 1'b1;
      tick();
      check($sformatf("tt%0d_sum", i),  64'(s1),  64'(tt_exp[i][1]));
      check($sformatf("tt%0d_cout", i), 64'(co1), 64'(tt_exp[i][0]));
      check($sformatf("tt%0d_ov", i),   64'(ov1), 64'd1);
    end

    // Asynchronous reset between edges with 1+1+1 on the inputs.
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; v1 = 1'b1;
    tick();
    check("pre_rst_sum", 64'(s1), 64'd1);
    check("pre_rst_co",  64'(co1), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_sum", 64'(s1), 64'd0);
    check("arst_co",  64'(co1), 64'd0);
    check("arst_ov",  64'(ov1), 64'd0);
    tick();
    tick();
    check("hold_sum", 64'(s1), 64'd0);
    check("hold_co",  64'(co1), 64'd0);
    check("hold_ov",  64'(ov1), 64'd0);
    #2;
    rst = 1'b0;
    #1;
    check("rel_noedge_ov", 64'(ov1), 64'd0);
    tick();
    check("rel_sum", 64'(s1), 64'd1);
    check("rel_co",  64'(co1), 64'd1);
    check("rel_ov",  64'(ov1), 64'd1);

    // WIDTH=8 carry ripple across all bits.
    a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1; v8 = 1'b1;
    tick();
    check("rip_sum", 64'(s8), 64'h00);
    check("rip_co",  64'(co8), 64'd1);
    check("rip_ov",  64'(ov8), 64'd1);

    a8 = 8'h7F; b8 = 8'h01; c8 = 1'b0;
    tick();
    check("msb_sum", 64'(s8), 64'h80);
    check("msb_co",  64'(co8), 64'd0);

    // WIDTH=8 maximum wrap.
    a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
    tick();
    check("wrap_sum", 64'(s8), 64'hFF);
    check("wrap_co",  64'(co8), 64'd1);

    // in_valid low: data still updates, out_valid drops.
    a8 = 8'h12; b8 = 8'h34; c8 = 1'b1; v8 = 1'b0;
    tick();
    check("nv_sum", 64'(s8), 64'h47);
    check("nv_co",  64'(co8), 64'd0);
    check("nv_ov",  64'(ov8), 64'd0);

    // Back-to-back streaming with random operands and random in_valid.
    for (int i = 0; i < 100; i++) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      c8 = 1'($urandom);
      v8 = 1'($urandom);
      exp9 = {1'b0, a8} + {1'b0, b8} + {8'd0, c8};
      tick();
      check($sformatf("st%0d_sum", i), 64'(s8),  64'(exp9[7:0]));
      check($sformatf("st%0d_co", i),  64'(co8), 64'(exp9[8]));
      check($sformatf("st%0d_ov", i),  64'(ov8), 64'(v8));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
